// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave register bank with byte strobes and privileged reg 0
module axi4_lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;

  w_state_t              w_state, w_state_next;
  logic                  ready_en;
  logic [31:0]           regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  aw_priv_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  aw_hs, w_hs, ar_hs, commit, commit_ok;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_priv;
  logic [31:0]           c_data;
  logic [3:0]            c_strb;
  logic                  c_hit, ar_hit;
  logic [IDX_W-1:0]      c_idx, ar_idx;
  logic                  unused_prot;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
           ((off >> 2) < ADDR_WIDTH'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  assign unused_prot = ^{arprot, awprot[2:1]};

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign arready = ready_en & ~rvalid;
  assign ar_hs   = arvalid & arready;

  // A commit happens on the edge where the second of the two halves arrives.
  assign commit = (aw_hs || (w_state == W_HAVE_ADDR)) && (w_hs || (w_state == W_HAVE_DATA));
  assign c_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : awaddr;
  assign c_priv = (w_state == W_HAVE_ADDR) ? aw_priv_q : awprot[0];
  assign c_data = (w_state == W_HAVE_DATA) ? w_data_q  : wdata;
  assign c_strb = (w_state == W_HAVE_DATA) ? w_strb_q  : wstrb;

  assign c_hit     = addr_hit(c_addr);
  assign c_idx     = addr_idx(c_addr);
  assign commit_ok = c_hit && ((c_idx != '0) || c_priv);
  assign ar_hit    = addr_hit(araddr);
  assign ar_idx    = addr_idx(araddr);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state  <= W_IDLE;
      ready_en <= 1'b0;
    end else begin
      w_state  <= w_state_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_next = W_RESP;
        else if (aw_hs)    w_state_next = W_HAVE_ADDR;
        else if (w_hs)     w_state_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)   w_state_next = W_RESP;
      W_HAVE_DATA: if (aw_hs)  w_state_next = W_RESP;
      W_RESP:      if (bready) w_state_next = W_IDLE;
      default:                 w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ready_en;
        wready  = ready_en;
      end
      W_HAVE_ADDR: wready  = 1'b1;
      W_HAVE_DATA: awready = 1'b1;
      W_RESP:      bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      aw_addr_q <= '0;
      aw_priv_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= awaddr;
        aw_priv_q <= awprot[0];
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        bresp <= commit_ok ? RESP_OKAY : RESP_SLVERR;
        if (commit_ok) begin
          for (int b = 0; b < 4; b++)
            if (c_strb[b]) regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

  // Nonblocking update means a read on the commit edge sees the pre-write value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_hit ? regs[ar_idx] : 32'h0;
      rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - scoreboard bench for axi4_lite_slave_regfile
module tb_axi4_lite_slave_regfile;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  axi4_lite_slave_regfile #(.ADDR_WIDTH(32), .NUM_REGS(8), .BASE_ADDR(32'h0)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=bresp %h expected=no response", bresp);
        end else begin
          logic [1:0] e;
          e = exp_b.pop_front();
          chk("bresp", 32'(bresp), 32'(e));
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=rdata %h expected=no response", rdata);
        end else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          chk("rdata", rdata, e[31:0]);
          chk("rresp", 32'(rresp), 32'(e[33:32]));
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, input logic [1:0] resp);
    int n;
    step();
    awaddr = addr; awprot = prot; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    exp_b.push_back(resp);
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    chk("aw_w_ready_timeout", 32'(awready && wready), 1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_latency", 32'(bvalid), 1);
    n = 0;
    while (bvalid && n < 20) begin step(); n++; end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n;
    step();
    araddr = addr; arvalid = 1'b1;
    exp_r.push_back({resp, data});
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    chk("ar_ready_timeout", 32'(arready), 1);
    step();
    arvalid = 1'b0;
    chk("r_latency", 32'(rvalid), 1);
    n = 0;
    while (rvalid && n < 20) begin step(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    areset = 1'b0;
    #1;
    chk("rel_awready_low", 32'(awready), 0);
    step();
    chk("rel_awready", 32'(awready), 1);
    chk("rel_wready", 32'(wready), 1);
    chk("rel_arready", 32'(arready), 1);

    // Simultaneous AW+W with partial strobe
    do_write(32'd16, 32'hF0B4A596, 4'b1011, 3'b000, 2'b00);
    do_read(32'd16, 32'hF000A596, 2'b00);

    // AW three cycles ahead of W, bready held low
    bready = 1'b0;
    step();
    awaddr = 32'd4; awprot = 3'b000; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("have_addr_awready", 32'(awready), 0);
    chk("have_addr_wready", 32'(wready), 1);
    step();
    chk("have_addr_wready2", 32'(wready), 1);
    step();
    chk("have_addr_wready3", 32'(wready), 1);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_hold_valid", 32'(bvalid), 1);
      chk("b_hold_resp", 32'(bresp), 0);
      step();
    end
    bready = 1'b1;
    step();
    chk("b_released", 32'(bvalid), 0);
    do_read(32'd4, 32'h12345678, 2'b00);

    // W ahead of AW
    step();
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("have_data_awready", 32'(awready), 1);
    chk("have_data_wready", 32'(wready), 0);
    step();
    awaddr = 32'd12; awprot = 3'b000; awvalid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    awvalid = 1'b0;
    chk("have_data_bvalid", 32'(bvalid), 1);
    step();
    do_read(32'd12, 32'h0BADF00D, 2'b00);

    // Decode misses and boundaries
    do_read(32'd32, 32'h0, 2'b10);
    do_write(32'd6, 32'hDEADBEEF, 4'hF, 3'b001, 2'b10);
    do_read(32'd4, 32'h12345678, 2'b00);
    do_write(32'd28, 32'hC0FFEE01, 4'hF, 3'b000, 2'b00);
    do_read(32'd28, 32'hC0FFEE01, 2'b00);
    do_write(32'd16, 32'h11111111, 4'b0000, 3'b000, 2'b00);
    do_read(32'd16, 32'hF000A596, 2'b00);

    // Privileged register 0
    do_write(32'd0, 32'hFFFFFFFF, 4'hF, 3'b010, 2'b10);
    do_read(32'd0, 32'h0, 2'b00);
    do_write(32'd0, 32'hFFFFFFFF, 4'hF, 3'b011, 2'b00);
    do_read(32'd0, 32'hFFFFFFFF, 2'b00);

    // Read and commit of the same register on the same edge
    step();
    awaddr = 32'd8; awprot = 3'b000; wdata = 32'hAAAA5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 32'd8; arvalid = 1'b1;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h0});
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_bvalid", 32'(bvalid), 1);
    chk("same_edge_rvalid", 32'(rvalid), 1);
    step();
    do_read(32'd8, 32'hAAAA5555, 2'b00);

    // Reset while a write response and read data are pending
    bready = 1'b0; rready = 1'b0;
    step();
    awaddr = 32'd20; awprot = 3'b000; wdata = 32'h00000011; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 32'd16; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_bvalid", 32'(bvalid), 1);
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    step();
    areset = 1'b1;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_awready", 32'(awready), 0);
    chk("mid_rst_wready", 32'(wready), 0);
    chk("mid_rst_arready", 32'(arready), 0);
    chk("mid_rst_rdata", rdata, 0);
    step();
    areset = 1'b0; bready = 1'b1; rready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) do_read(32'(i * 4), 32'h0, 2'b00);

    repeat (3) step();
    chk("b_queue_drained", 32'(exp_b.size()), 0);
    chk("r_queue_drained", 32'(exp_r.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite slave register bank that sits directly downstream of the team's AXI4-Lite interconnect stage and terminates its write and read channels. It decodes word addresses into a bank of NUM_REGS 32-bit registers, applies byte strobes on writes, and enforces a privileged-access rule on register 0. It returns OKAY/SLVERR responses per the AXI4-Lite handshake rules.

## Interface
- ADDR_WIDTH, 32, width of awaddr/araddr
- NUM_REGS, 8, number of 32-bit registers (1..256)
- BASE_ADDR, 0, byte address of register 0 (word aligned)
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset, asynchronous and active-high
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  write protection; bit0 = privileged
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes, bit n enables wdata[8n+7:8n]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  read protection (ignored)
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready

## Operation
- Decode: hit when addr[1:0]==0, addr>=BASE_ADDR, and idx=(addr-BASE_ADDR)>>2 < NUM_REGS; otherwise SLVERR. Subtraction is done at ADDR_WIDTH; underflow is a miss.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready=wready=1. AW-only -> W_HAVE_ADDR (address/prot latched). W-only -> W_HAVE_DATA (data/strb latched). Both in same cycle -> commit, -> W_RESP.
  - W_HAVE_ADDR: awready=0, wready=1; W handshake -> commit, -> W_RESP.
  - W_HAVE_DATA: wready=0, awready=1; AW handshake -> commit, -> W_RESP.
  - W_RESP: awready=wready=0, bvalid=1; bresp held stable; bvalid&bready -> W_IDLE.
- Commit: on a hit, and if idx!=0 or awprot[0]==1, update each byte whose wstrb bit is set, bresp=OKAY. Unprivileged write to idx 0 or any miss: no register change, bresp=SLVERR. wstrb=4'b0000 on a hit is OKAY with no change.
- Read path: arready=1 when rvalid==0. AR handshake latches rdata=reg[idx], rresp=OKAY (miss: rdata=0, rresp=SLVERR), rvalid=1. rvalid&rready clears rvalid. rdata/rresp stable while rvalid=1.
- Read and write paths are independent. Same-register read and commit on the same edge: the read returns the pre-write value.
- areset: all registers cleared to 0, FSM -> W_IDLE, all outputs 0. Any in-flight transaction is dropped with no response.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0. awready/wready/arready are registered and go to 1 on the first rising edge after areset falls.
- Write latency: bvalid rises 1 cycle after the edge completing the later of the AW/W handshakes. Register contents are visible from that same edge.
- Read latency: rvalid rises 1 cycle after the AR handshake edge.
- Back-to-back behaviour:
  - arready returns high the cycle after rvalid&rready, so peak throughput is 1 read per 2 cycles.
  - Writes return to W_IDLE the cycle after bvalid&bready, so peak throughput is 1 write per 2 cycles.
- bvalid and rvalid never drop without the matching ready, except on areset.

## Test plan
- Reset, then a simultaneous AW+W to awaddr=16, wdata=32'hF0B4A596, wstrb=4'b1011 -> bvalid 1 cycle later with bresp=00. A subsequent read of araddr=16 gives rdata=32'hF000A596, rresp=00.
- AW at awaddr=4 three cycles before W with wdata=32'h12345678, wstrb=4'hF, with bready held low for 4 cycles -> wready stays high while W_HAVE_ADDR. bvalid holds with bresp=00 until bready. Read of 4 returns 32'h12345678.
- Read araddr=32 (idx 8, NUM_REGS=8) -> rvalid with rresp=10, rdata=0. Write awaddr=6 (misaligned) -> bresp=10 and no register changes.
- Write to awaddr=0 with awprot=3'b010 and wdata=32'hFFFFFFFF -> bresp=10, reg0 stays 0. Repeat with awprot=3'b011 -> bresp=00, reg0=32'hFFFFFFFF.
- Write 32'hAAAA5555 to reg 2 while an AR to address 8 handshakes on the commit edge -> rdata returns the old value (0). The next read returns 32'hAAAA5555.
- Assert areset while in W_RESP with rvalid=1 -> bvalid, rvalid and all readies drop immediately, and all registers read back 0 after release.
